// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: reset vector, redirect channel
// indices and the incoming-vs-pending redirect priority rule.
package pc_pkg;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'hbfc00000;

   typedef enum logic [1:0] {
      REDIR_EXC    = 2'd0,
      REDIR_ERET   = 2'd1,
      REDIR_BRANCH = 2'd2
   } redir_idx_e;

   // Lower index is higher priority; on a tie the newer (incoming) request wins.
   function automatic logic redir_wins(input int unsigned inc_idx, input int unsigned pend_idx);
      return inc_idx <= pend_idx;
   endfunction

endpackage

// File: rtl/pc_gen_redirect_arbiter.sv
// Combinational lowest-index priority encoder over the redirect channels, with
// the winning channel's target muxed out. Zero latency, no flow control.
module redirect_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int NUM_REDIRECT = 3,
   parameter int IDX_W        = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1
) (
   input  logic [NUM_REDIRECT-1:0]        redirect_valid,
   input  logic [NUM_REDIRECT*ADDR_W-1:0] redirect_target,
   output logic                           inc_vld,
   output logic [IDX_W-1:0]               inc_idx,
   output logic [ADDR_W-1:0]              inc_tgt
);

   always_comb begin
      inc_vld = 1'b0;
      inc_idx = '0;
      inc_tgt = '0;
      // Walk from the top down so the lowest asserted index is the last writer.
      for (int k = NUM_REDIRECT - 1; k >= 0; k--) begin
         if (redirect_valid[k]) begin
            inc_vld = 1'b1;
            inc_idx = IDX_W'(k);
            inc_tgt = redirect_target[k*ADDR_W +: ADDR_W];
         end
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with prioritised redirects and a one-entry pending buffer.
// Redirects load in one edge when enabled; while stalled the best one is held.
module pc_gen
   import pc_pkg::*;
#(
   parameter int          ADDR_W       = 32,
   parameter int          NUM_REDIRECT = 3,
   parameter int          FETCH_BYTES  = 4,
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   localparam int         IDX_W        = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [NUM_REDIRECT-1:0]        redirect_valid_i,
   input  logic [NUM_REDIRECT*ADDR_W-1:0] redirect_target_i,
   output logic [ADDR_W-1:0]              pc,
   output logic                           pc_valid_o,
   output logic                           redirect_taken_o,
   output logic [IDX_W-1:0]               redirect_src_o,
   output logic                           addr_err_o
);

   logic              inc_vld;
   logic [IDX_W-1:0]  inc_idx;
   logic [ADDR_W-1:0] inc_tgt;

   logic              pend_vld;
   logic [IDX_W-1:0]  pend_idx;
   logic [ADDR_W-1:0] pend_tgt;

   logic              cand_vld;
   logic [IDX_W-1:0]  cand_idx;
   logic [ADDR_W-1:0] cand_tgt;

   redirect_arbiter #(
      .ADDR_W       (ADDR_W),
      .NUM_REDIRECT (NUM_REDIRECT),
      .IDX_W        (IDX_W)
   ) u_arb (
      .redirect_valid  (redirect_valid_i),
      .redirect_target (redirect_target_i),
      .inc_vld         (inc_vld),
      .inc_idx         (inc_idx),
      .inc_tgt         (inc_tgt)
   );

   always_comb begin
      cand_vld = inc_vld | pend_vld;
      cand_idx = pend_idx;
      cand_tgt = pend_tgt;
      if (inc_vld && (!pend_vld || redir_wins(32'(inc_idx), 32'(pend_idx)))) begin
         cand_idx = inc_idx;
         cand_tgt = inc_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc               <= ADDR_W'(RESET_VECTOR);
         pc_valid_o       <= 1'b0;
         pend_vld         <= 1'b0;
         pend_idx         <= '0;
         pend_tgt         <= '0;
         redirect_taken_o <= 1'b0;
         redirect_src_o   <= '0;
      end else begin
         pc_valid_o       <= 1'b1;
         redirect_taken_o <= 1'b0;
         // The first edge out of reset behaves as a stall so RESET_VECTOR is fetched.
         if (pc_valid_o && en) begin
            if (cand_vld) begin
               pc               <= cand_tgt;
               pend_vld         <= 1'b0;
               redirect_taken_o <= 1'b1;
               redirect_src_o   <= cand_idx;
            end else begin
               pc <= pc + ADDR_W'(FETCH_BYTES);
            end
         end else if (cand_vld) begin
            pend_vld <= 1'b1;
            pend_idx <= cand_idx;
            pend_tgt <= cand_tgt;
         end
      end
   end

   assign addr_err_o = |pc[1:0];

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the single-branch PC register.
- Generates the fetch PC with NUM_REDIRECT prioritised redirect channels (e.g. exception, ERET, branch), a configurable fetch step and a one-entry pending-redirect buffer.
- A redirect that arrives while fetch is stalled is kept and applied on the next enabled cycle.
- Sits at the head of the IF stage and drives the instruction-fetch address.

Parameters:
- ADDR_W, 32, PC width in bits.
- NUM_REDIRECT, 3, number of redirect channels. Index 0 has the highest priority.
- FETCH_BYTES, 4, PC increment per enabled cycle. Must be a power of two, ≥4.
- RESET_VECTOR, 32'hbfc00000, PC value on reset. Only the low ADDR_W bits are used.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  fetch advance enable. 0 = stall.
- redirect_valid_i  in  NUM_REDIRECT  per-channel redirect request. Single-cycle pulse.
- redirect_target_i  in  NUM_REDIRECT*ADDR_W  per-channel target. Channel k occupies bits [k*ADDR_W +: ADDR_W].
- pc  out  ADDR_W  current fetch PC.
- pc_valid_o  out  1  PC is valid for fetch.
- redirect_taken_o  out  1  one-cycle pulse: pc was loaded from a redirect on the last edge.
- redirect_src_o  out  $clog2(NUM_REDIRECT) (min 1)  channel index that produced the last redirect load.
- addr_err_o  out  1  pc not aligned to 4 bytes (combinational from pc).

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_VECTOR, pc_valid_o=0.
  - pending buffer cleared.
  - redirect_taken_o=0, redirect_src_o=0.
  - rst overrides every other input, including redirect pulses in the same cycle; those pulses are dropped.
- pc_valid_o goes to 1 at the first posedge with rst=0 and stays 1 until the next reset. That edge does not change pc, so the first fetch address is RESET_VECTOR.
- Incoming select: among the asserted redirect_valid_i bits, the lowest index wins. This gives inc_vld, inc_idx and inc_tgt.
- Pending buffer holds pend_vld, pend_idx and pend_tgt.
- Candidate selection:
  - If inc_vld and pend_vld, incoming wins when inc_idx ≤ pend_idx (newer wins a tie); otherwise pending wins.
  - If only one of them is valid, that one is the candidate.
- Posedge with rst=0, pc_valid_o=1, en=1:
  - Candidate exists: pc ← candidate target, pend_vld ← 0, redirect_taken_o ← 1, redirect_src_o ← candidate index.
  - No candidate: pc ← pc + FETCH_BYTES, wrapping modulo 2^ADDR_W; redirect_taken_o ← 0.
  - Zero-latency path: a redirect pulsed in the cycle en=1 is loaded on that same edge.
- Posedge with rst=0, en=0 (stall):
  - pc holds; redirect_taken_o ← 0.
  - If a candidate exists, the pending buffer ← candidate. A lower-priority incoming redirect is discarded while a higher-priority one is pending.
- Posedge with rst=0, pc_valid_o=0 (first cycle after reset):
  - Treated as a stall regardless of en. Redirects are buffered, not applied.
- redirect_src_o holds its value between redirect loads.
- Targets are loaded unmodified; misaligned values are not corrected. addr_err_o = |pc[1:0] and is 0 after reset.
- Latency: redirect to pc takes 1 edge when en=1. When stalled, it applies on the first enabled edge.

Decomposition:
- Package pc_pkg holds:
  - RESET_VECTOR default.
  - Redirect index enum: REDIR_EXC=0, REDIR_ERET=1, REDIR_BRANCH=2.
  - Function redir_wins(inc_idx, pend_idx).
- Sub-module redirect_arbiter: combinational lowest-index priority encoder plus target mux. Parametrised by NUM_REDIRECT and ADDR_W. Outputs inc_vld, inc_idx, inc_tgt.
- pc_gen instantiates redirect_arbiter and contains the pending buffer, pc register and output flags.

Test Plan:
- Reset then en=1 continuously → pc_valid_o=1 after the first edge. pc sequence is bfc00000 (two cycles), bfc00004, bfc00008. With FETCH_BYTES=8, the step is 8.
- en=1, pulse channel 2 with target 80001000 → next edge pc=80001000, redirect_taken_o=1 for one cycle, redirect_src_o=2. Next edge pc=80001004.
- en=0, pulse channel 2 (80002000), then channel 0 two cycles later (bfc00380), hold 3 cycles, set en=1 → pc=bfc00380, src=0. Channel 2 redirect discarded, pc then steps sequentially.
- en=0, pend ch1=80003000. Next cycle en=1 with ch2=80004000 and ch1=80005000 pulsed together → pc=80005000, src=1 (incoming wins tie). Then repeat with a pending ch0 entry and an incoming ch2 → pending ch0 target wins.
- pc=fffffffc, en=1, no redirect → pc=00000000 (wrap). Then redirect to 80000002 → addr_err_o=1.
- Pending redirect present, assert rst for one cycle → pc=bfc00000, pend cleared, redirect_taken_o=0. After release, no stale redirect is applied.
